// File: rtl/snitch_icache_pkg.sv
// Shared icache types: refill coalescer
// pending-line table entry and helpers.
package snitch_icache_pkg;

  localparam int unsigned ICACHE_AW    = 32;
  localparam int unsigned ICACHE_PORTS = 4;

  typedef enum logic [1:0] {
    FREE,
    WAIT,
    DELIVER
  } entry_state_e;

  typedef struct packed {
    entry_state_e            state;
    logic [ICACHE_AW-1:0]    addr;
    logic [ICACHE_PORTS-1:0] mask;
  } pending_entry_t;

  function automatic logic [ICACHE_AW-1:0] line_addr(
    input logic [ICACHE_AW-1:0] a,
    input int unsigned          align
  );
    return (a >> align) << align;
  endfunction

endpackage

// File: rtl/snitch_icache_refill_coalescer_arb.sv
// Round-robin index arbiter; pointer moves
// past the granted port only on handshake.
module snitch_icache_refill_coalescer_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          hs_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] ptr_q;
  logic [IW:0]   sum;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + (IW + 1)'(i);
      if (sum >= (IW + 1)'(N)) begin
        sum = sum - (IW + 1)'(N);
      end
      if (req_i[sum[IW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = sum[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (hs_i && valid_o) begin
      if (idx_o == IW'(N - 1)) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= idx_o + IW'(1);
      end
    end
  end

endmodule

// File: rtl/snitch_icache_refill_coalescer.sv
// Merges L0 refills per cache line, issues one
// downstream request per line, broadcasts returns.
module snitch_icache_refill_coalescer
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_PORTS      = 4,
  parameter int unsigned FETCH_AW      = 32,
  parameter int unsigned LINE_WIDTH    = 128,
  parameter int unsigned LINE_ALIGN    = 4,
  parameter int unsigned PENDING_COUNT = 4,
  parameter int unsigned IDW           = $clog2(PENDING_COUNT)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NR_PORTS-1:0][FETCH_AW-1:0]  in_req_addr_i,
  input  logic [NR_PORTS-1:0]                in_req_valid_i,
  output logic [NR_PORTS-1:0]                in_req_ready_o,
  output logic [LINE_WIDTH-1:0]              in_rsp_data_o,
  output logic                               in_rsp_error_o,
  output logic [NR_PORTS-1:0]                in_rsp_valid_o,
  input  logic [NR_PORTS-1:0]                in_rsp_ready_i,
  output logic [FETCH_AW-1:0]                out_req_addr_o,
  output logic [IDW-1:0]                     out_req_id_o,
  output logic                               out_req_valid_o,
  input  logic                               out_req_ready_i,
  input  logic [LINE_WIDTH-1:0]              out_rsp_data_i,
  input  logic                               out_rsp_error_i,
  input  logic [IDW-1:0]                     out_rsp_id_i,
  input  logic                               out_rsp_valid_i,
  output logic                               out_rsp_ready_o,
  output logic                               coalesce_o
);

  localparam int unsigned PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

  pending_entry_t tbl_q [PENDING_COUNT];
  pending_entry_t tbl_d [PENDING_COUNT];

  logic                  oreg_valid_q;
  logic [FETCH_AW-1:0]   oreg_addr_q;
  logic [IDW-1:0]        oreg_id_q;
  logic                  dlv_valid_q;
  logic [IDW-1:0]        dlv_idx_q;
  logic [LINE_WIDTH-1:0] data_q;
  logic                  err_q;
  logic                  coal_q;

  logic [PW-1:0]         gnt_idx;
  logic                  gnt_valid;
  logic [FETCH_AW-1:0]   gnt_line;
  logic [NR_PORTS-1:0]   pbit;
  logic                  hit_wait;
  logic                  hit_dlv;
  logic [IDW-1:0]        hit_idx;
  logic                  free_any;
  logic [IDW-1:0]        free_idx;
  logic                  rsp_hs;
  logic                  merge;
  logic                  alloc;
  logic                  req_hs;
  logic [NR_PORTS-1:0]   dlv_mask;
  logic [NR_PORTS-1:0]   dlv_left;
  logic                  dlv_done;

  snitch_icache_refill_coalescer_arb #(
    .N  (NR_PORTS),
    .IW (PW)
  ) i_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (in_req_valid_i),
    .hs_i    (req_hs),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  assign gnt_line = line_addr(in_req_addr_i[gnt_idx], LINE_ALIGN);

  always_comb begin
    pbit          = '0;
    pbit[gnt_idx] = 1'b1;
  end

  // Lowest-index FREE entry wins the allocation.
  always_comb begin
    hit_wait = 1'b0;
    hit_dlv  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int e = PENDING_COUNT - 1; e >= 0; e--) begin
      if (tbl_q[e].state == FREE) begin
        free_any = 1'b1;
        free_idx = IDW'(e);
      end
      if (tbl_q[e].addr == gnt_line) begin
        if (tbl_q[e].state == WAIT) begin
          hit_wait = 1'b1;
          hit_idx  = IDW'(e);
        end
        if (tbl_q[e].state == DELIVER) begin
          hit_dlv = 1'b1;
        end
      end
    end
  end

  assign out_rsp_ready_o = !dlv_valid_q;
  assign rsp_hs = out_rsp_valid_i && out_rsp_ready_o;

  assign merge = gnt_valid && hit_wait &&
                 !(rsp_hs && (out_rsp_id_i == hit_idx));
  assign alloc = gnt_valid && !hit_wait && !hit_dlv &&
                 free_any && (!oreg_valid_q || out_req_ready_i);
  assign req_hs = merge || alloc;

  always_comb begin
    in_req_ready_o          = '0;
    in_req_ready_o[gnt_idx] = req_hs;
  end

  assign dlv_mask = dlv_valid_q ? tbl_q[dlv_idx_q].mask : '0;
  assign dlv_left = dlv_mask & ~in_rsp_ready_i;
  assign dlv_done = dlv_valid_q && (dlv_left == '0);

  // Merge, allocate, capture and delivery always hit distinct entries.
  always_comb begin
    tbl_d = tbl_q;
    if (merge) begin
      tbl_d[hit_idx].mask = tbl_q[hit_idx].mask | pbit;
    end
    if (alloc) begin
      tbl_d[free_idx].state = WAIT;
      tbl_d[free_idx].addr  = gnt_line;
      tbl_d[free_idx].mask  = pbit;
    end
    if (rsp_hs) begin
      tbl_d[out_rsp_id_i].state = DELIVER;
    end
    if (dlv_valid_q) begin
      tbl_d[dlv_idx_q].mask = dlv_left;
      if (dlv_done) begin
        tbl_d[dlv_idx_q].state = FREE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < PENDING_COUNT; e++) begin
        tbl_q[e] <= '0;
      end
    end else begin
      for (int e = 0; e < PENDING_COUNT; e++) begin
        tbl_q[e] <= tbl_d[e];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      oreg_valid_q <= 1'b0;
      oreg_addr_q  <= '0;
      oreg_id_q    <= '0;
    end else if (alloc) begin
      oreg_valid_q <= 1'b1;
      oreg_addr_q  <= gnt_line;
      oreg_id_q    <= free_idx;
    end else if (out_req_ready_i) begin
      oreg_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dlv_valid_q <= 1'b0;
      dlv_idx_q   <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else if (rsp_hs) begin
      dlv_valid_q <= 1'b1;
      dlv_idx_q   <= out_rsp_id_i;
      data_q      <= out_rsp_data_i;
      err_q       <= out_rsp_error_i;
    end else if (dlv_done) begin
      dlv_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      coal_q <= 1'b0;
    end else begin
      coal_q <= merge;
    end
  end

  assign in_rsp_valid_o  = dlv_mask;
  assign in_rsp_data_o   = data_q;
  assign in_rsp_error_o  = err_q;
  assign out_req_valid_o = oreg_valid_q;
  assign out_req_addr_o  = oreg_addr_q;
  assign out_req_id_o    = oreg_id_q;
  assign coalesce_o      = coal_q;

  a_rsp_id_wait: assert property (
    @(posedge clk_i) disable iff (rst_i)
    rsp_hs |-> (tbl_q[out_rsp_id_i].state == WAIT)
  );

endmodule
